// File: rtl/poly_pkg.sv
// Shared constants for the Horner polynomial evaluator: FSM encodings and
// the wrap/saturate mode selectors.
package poly_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

endpackage

// File: rtl/poly_mac.sv
// One Horner step: next_acc = acc*x + c, with overflow flag and optional
// clamp to all-ones when the exact sum does not fit in WIDTH bits.
module poly_mac
   import poly_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] next_acc,
   output logic             ovf
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH:0]   full;

   // The exact sum needs at most 2*WIDTH bits; the spare top bit keeps the add carry-safe.
   assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x};
   assign full = {1'b0, prod} + {{(WIDTH+1){1'b0}}, c};
   assign ovf  = |full[2*WIDTH:WIDTH];

   assign next_acc = (SATURATE == MODE_SAT && ovf) ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

// File: rtl/poly_eval_horner.sv
// Parametrised polynomial evaluator: one Horner multiply-add per clock with a
// start/busy/done handshake and an IDLE-only coefficient write port.
module poly_eval_horner
   import poly_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEGREE   = 3,
   parameter int SATURATE = MODE_WRAP,
   localparam int IDX_W   = (DEGREE + 1 > 1) ? $clog2(DEGREE + 1) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             coef_wr,
   input  logic [IDX_W-1:0] coef_idx,
   input  logic [WIDTH-1:0] coef_data,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DEGREE);
   localparam logic [IDX_W-1:0] CNT_TOP = IDX_W'(DEGREE - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] coef [DEGREE+1];
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x_q;
   logic [IDX_W-1:0] cnt;
   logic             ovf_q;
   logic [WIDTH-1:0] mac_next;
   logic             mac_ovf;
   logic             coef_we;

   assign busy = (state == S_RUN) || (state == S_DONE);
   assign done = (state == S_DONE);

   // Writes only land while idle and not being accepted, so a running evaluation never sees a change.
   assign coef_we = coef_wr && (state == S_IDLE) && !start && (coef_idx <= MAX_IDX);

   poly_mac #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_mac (
      .acc      (acc),
      .x        (x_q),
      .c        (coef[cnt]),
      .next_acc (mac_next),
      .ovf      (mac_ovf)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i <= DEGREE; i++) begin
            coef[i] <= '0;
         end
      end else if (coef_we) begin
         coef[coef_idx] <= coef_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         acc      <= '0;
         x_q      <= '0;
         cnt      <= '0;
         ovf_q    <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_q   <= x;
                  acc   <= coef[DEGREE];
                  cnt   <= CNT_TOP;
                  ovf_q <= 1'b0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= mac_next;
               ovf_q <= ovf_q | mac_ovf;
               // Outputs are captured on the way into DONE so they are valid during the done pulse.
               if (cnt == '0) begin
                  result   <= mac_next;
                  overflow <= ovf_q | mac_ovf;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt - IDX_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
